mmio_mem_hub: RTL and testbench

Parametrised successor to the pipeline CPU's unified memory/MMIO block. It provides two ports:
- Port A: a read-only instruction port with an exception-vector overlay.
- Port B: a load/store port with byte-lane writes.

Both ports share one inferred word RAM, and port B also reaches a configurable bank of synchronised input channels, a confirm button and output registers. It sits between the pipeline's IF/MEM stages and the board I/O, and uses a registered one-cycle request/valid handshake on both ports.

---
 rtl/mmio_mem_hub.sv | 108 ++++++++++
 tb/tb_mmio_mem_hub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_mem_hub.sv
// mmio_mem_hub: shared word RAM with an instruction read port (exception overlay) and a load/store port reaching RAM and board MMIO
// Ports: clk/reset (async active-low); a_* read-only instruction port; b_* load/store port with byte enables and misalignment error;
// sw_in/btn_confirm raw board inputs; out_regs packed output registers.
module mmio_mem_hub #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14,
  parameter logic [15:0] MMIO_HI = 16'hFFFF,
  parameter logic [15:0] EXC_HI = 16'h1C09,
  parameter logic [31:0] EXC_WORD = 32'h0000_0013,
  parameter int N_IN = 2,
  parameter int IN_W = 16,
  parameter int N_OUT = 3,
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_req,
  input  logic [31:0]            a_addr,
  output logic                   a_rvalid,
  output logic [DATA_W-1:0]      a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [3:0]             b_be,
  input  logic [31:0]            b_addr,
  input  logic [DATA_W-1:0]      b_wdata,
  output logic                   b_rvalid,
  output logic [DATA_W-1:0]      b_rdata,
  output logic                   b_err,
  input  logic [N_IN*IN_W-1:0]   sw_in,
  input  logic                   btn_confirm,
  output logic [N_OUT*OUT_W-1:0] out_regs
);
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] a_idx, b_idx;
  logic [N_IN*IN_W-1:0] sw_s1, sw_s2;
  logic btn_s1, btn_s2, btn_prev, pending;
  logic a_exc_q, b_sel_ram;
  logic [DATA_W-1:0] a_ram_q, b_ram_q, b_mmio_q, mmio_rd, mask, stat_word;
  logic b_ok, b_mis, b_mmio, b_ram_we, stat_rd;
  logic [15:0] off;
  logic [N_IN:0][DATA_W-1:0] in_acc;
  logic [N_OUT:0][DATA_W-1:0] out_acc;
  logic unused_a;
  assign unused_a = ^a_addr[1:0];
  assign a_idx = a_addr[MEM_AW+1:2];
  assign b_idx = b_addr[MEM_AW+1:2];
  assign off = b_addr[15:0];
  assign b_mis = b_req & |b_addr[1:0];
  assign b_ok = b_req & ~|b_addr[1:0];
  assign b_mmio = b_addr[31:16] == MMIO_HI;
  assign b_ram_we = b_ok & b_we & ~b_mmio;
  assign stat_rd = b_ok & b_mmio & ~b_we & (off == 16'h0080);
  assign mask = {{8{b_be[3]}}, {8{b_be[2]}}, {8{b_be[1]}}, {8{b_be[0]}}};
  assign stat_word = (off == 16'h0080) ? {{(DATA_W-2){1'b0}}, btn_s2, pending} : '0;
  assign in_acc[0] = '0;
  assign out_acc[0] = '0;
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign in_acc[i+1] = in_acc[i] | ((off == 16'(4*i)) ? DATA_W'(sw_s2[i*IN_W +: IN_W]) : '0);
  end
  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    logic [OUT_W-1:0] r;
    logic hit;
    assign hit = off == 16'h0100 + 16'(4*j);
    always_ff @(posedge clk or negedge reset)
      if (!reset) r <= '0;
      else if (b_ok & b_mmio & b_we & hit) r <= (r & ~mask[OUT_W-1:0]) | (b_wdata[OUT_W-1:0] & mask[OUT_W-1:0]);
    assign out_regs[j*OUT_W +: OUT_W] = r;
    assign out_acc[j+1] = out_acc[j] | (hit ? DATA_W'(r) : '0);
  end
  assign mmio_rd = in_acc[N_IN] | out_acc[N_OUT] | stat_word;
  // Reads sample the pre-write word, so a same-edge write is invisible to both ports (read-first).
  always_ff @(posedge clk) begin
    if (a_req) a_ram_q <= mem[a_idx];
    if (b_req) b_ram_q <= mem[b_idx];
    if (b_ram_we) mem[b_idx] <= (mem[b_idx] & ~mask) | (b_wdata & mask);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_rvalid <= 1'b0;
      a_exc_q <= 1'b0;
      b_rvalid <= 1'b0;
      b_err <= 1'b0;
      b_sel_ram <= 1'b0;
      b_mmio_q <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_prev <= 1'b0;
      pending <= 1'b0;
    end else begin
      a_rvalid <= a_req;
      a_exc_q <= a_addr[31:16] == EXC_HI;
      b_rvalid <= b_req;
      b_err <= b_mis;
      b_sel_ram <= b_ok & ~b_mmio;
      b_mmio_q <= (b_ok & b_mmio) ? mmio_rd : '0;
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      btn_s1 <= btn_confirm;
      btn_s2 <= btn_s1;
      btn_prev <= btn_s2;
      pending <= (btn_s2 & ~btn_prev) | (pending & ~stat_rd);
    end
  // Response mux stays zero when idle or misaligned because b_sel_ram and b_mmio_q are both cleared then.
  assign a_rdata = a_rvalid ? (a_exc_q ? EXC_WORD : a_ram_q) : '0;
  assign b_rdata = b_sel_ram ? b_ram_q : b_mmio_q;
endmodule

// File: tb/tb_mmio_mem_hub.sv
// tb_mmio_mem_hub: directed bench with a behavioural reference model checked every cycle
module tb_mmio_mem_hub;
  logic clk = 1'b0, reset = 1'b1;
  logic a_req, b_req, b_we, btn_confirm, a_rvalid, b_rvalid, b_err;
  logic [3:0] b_be;
  logic [31:0] a_addr, b_addr, b_wdata, a_rdata, b_rdata, sw_in;
  logic [95:0] out_regs;
  int total = 0, bad = 0;
  logic [31:0] mem_m [int];
  logic [31:0] out_m [3];
  logic ea_v, ea_k, eb_v, eb_e, eb_k, pend, bh1, bh2, bh3;
  logic [31:0] ea_d, eb_d, swh1, swh2;
  always #5 clk = ~clk;
  mmio_mem_hub dut (.clk(clk), .reset(reset), .a_req(a_req), .a_addr(a_addr), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_err(b_err), .sw_in(sw_in), .btn_confirm(btn_confirm), .out_regs(out_regs));
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin : model
    int idx;
    int j;
    logic [31:0] m;
    logic [15:0] off;
    logic clr;
    if (!reset) begin
      {ea_v, eb_v, eb_e, pend, bh1, bh2, bh3} = '0;
      {ea_k, eb_k} = 2'b11;
      {ea_d, eb_d, swh1, swh2} = '0;
      for (int k = 0; k < 3; k++) out_m[k] = '0;
    end else begin
      clr = 1'b0;
      ea_v = a_req; ea_k = 1'b1; ea_d = '0;
      if (a_req) begin
        if (a_addr[31:16] == 16'h1C09) ea_d = 32'h13;
        else begin
          idx = int'(a_addr[15:2]);
          ea_k = mem_m.exists(idx);
          if (ea_k) ea_d = mem_m[idx];
        end
      end
      eb_v = b_req; eb_e = 1'b0; eb_k = 1'b1; eb_d = '0;
      m = {{8{b_be[3]}}, {8{b_be[2]}}, {8{b_be[1]}}, {8{b_be[0]}}};
      if (b_req) begin
        if (b_addr[1:0] != 2'b00) eb_e = 1'b1;
        else if (b_addr[31:16] == 16'hFFFF) begin
          off = b_addr[15:0];
          if (off == 16'h0000) eb_d = {16'h0, swh2[15:0]};
          else if (off == 16'h0004) eb_d = {16'h0, swh2[31:16]};
          else if (off == 16'h0080) begin
            eb_d = {30'h0, bh2, pend};
            clr = !b_we;
          end else if (off >= 16'h0100 && off < 16'h010C && off[1:0] == 2'b00) begin
            j = int'(off - 16'h0100) / 4;
            eb_d = out_m[j];
            if (b_we) out_m[j] = (out_m[j] & ~m) | (b_wdata & m);
          end
        end else begin
          idx = int'(b_addr[15:2]);
          eb_k = mem_m.exists(idx);
          if (eb_k) eb_d = mem_m[idx];
          if (b_we && (eb_k || b_be == 4'hF)) mem_m[idx] = (eb_d & ~m) | (b_wdata & m);
        end
      end
      pend = (bh2 & !bh3) | (pend & !clr);
      bh3 = bh2; bh2 = bh1; bh1 = btn_confirm;
      swh2 = swh1; swh1 = sw_in;
    end
  end
  always @(posedge clk) begin
    #1;
    chk("a_rvalid", a_rvalid, ea_v);
    if (ea_v && ea_k) chk("a_rdata", a_rdata, ea_d);
    chk("b_rvalid", b_rvalid, eb_v);
    chk("b_err", b_err, eb_e);
    if (eb_v && eb_k) chk("b_rdata", b_rdata, eb_d);
    chk("out_regs", out_regs, {out_m[2], out_m[1], out_m[0]});
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic bop(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
    step();
    b_req = 1'b0; b_we = 1'b0;
  endtask
  task automatic ar(input logic [31:0] addr);
    a_req = 1'b1; a_addr = addr;
    step();
    a_req = 1'b0;
  endtask
  initial begin
    a_req = 0; a_addr = 0; b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0; sw_in = 0; btn_confirm = 0;
    reset = 1'b0;
    #1;
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_out_regs", out_regs, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    bop(1, 4'hF, 32'h10, 32'hDEADBEEF);
    ar(32'h10);
    chk("a_readback", a_rdata, 32'hDEADBEEF);
    bop(1, 4'b0010, 32'h10, 32'h0000_5500);
    chk("write_old_word", b_rdata, 32'hDEADBEEF);
    bop(0, 4'h0, 32'h10, 0);
    chk("byte_lane", b_rdata, 32'hDEAD55EF);
    bop(1, 4'hF, 32'h4, 32'hCAFE0004);
    ar(32'h1C09_0004);
    chk("exc_overlay", a_rdata, 32'h13);
    ar(32'h4);
    chk("a_plain", a_rdata, 32'hCAFE0004);
    chk("a_plain_err", b_err, 0);
    bop(1, 4'hF, 32'h12, 32'h0);
    chk("mis_valid", b_rvalid, 1);
    chk("mis_err", b_err, 1);
    chk("mis_data", b_rdata, 0);
    bop(0, 4'h0, 32'h10, 0);
    chk("mis_no_write", b_rdata, 32'hDEAD55EF);
    bop(1, 4'h0, 32'h10, 32'hFFFF_FFFF);
    chk("be0_valid", b_rvalid, 1);
    bop(0, 4'h0, 32'h10, 0);
    chk("be0_no_write", b_rdata, 32'hDEAD55EF);
    bop(1, 4'hF, 32'h20, 32'h0101_0101);
    a_req = 1; a_addr = 32'h20;
    b_req = 1; b_we = 1; b_be = 4'hF; b_addr = 32'h20; b_wdata = 32'h0202_0202;
    step();
    a_req = 0; b_req = 0; b_we = 0;
    chk("collide_a_old", a_rdata, 32'h0101_0101);
    bop(0, 4'h0, 32'h20, 0);
    chk("collide_b_new", b_rdata, 32'h0202_0202);
    sw_in = {16'h1234, 16'h0000};
    repeat (3) step();
    bop(0, 4'h0, 32'hFFFF_0004, 0);
    chk("sw_ch1", b_rdata, 32'h0000_1234);
    bop(1, 4'hF, 32'h104, 32'h1111_2222);
    bop(1, 4'h1, 32'hFFFF_0104, 32'h0000_00A5);
    chk("out_reg1", out_regs[63:32], 32'h0000_00A5);
    bop(0, 4'h0, 32'h104, 0);
    chk("ram41_kept", b_rdata, 32'h1111_2222);
    bop(1, 4'hF, 32'hFFFF_0108, 32'h89AB_CDEF);
    bop(0, 4'h0, 32'hFFFF_0108, 0);
    chk("out_reg2_rd", b_rdata, 32'h89AB_CDEF);
    btn_confirm = 1;
    repeat (4) step();
    btn_confirm = 0;
    repeat (4) step();
    bop(0, 4'h0, 32'hFFFF_0080, 0);
    chk("status_pend", b_rdata, 32'h1);
    bop(0, 4'h0, 32'hFFFF_0080, 0);
    chk("status_clr", b_rdata, 32'h0);
    btn_confirm = 1;
    repeat (2) step();
    bop(0, 4'h0, 32'hFFFF_0080, 0);
    chk("status_race", b_rdata, 32'h2);
    bop(0, 4'h0, 32'hFFFF_0080, 0);
    chk("status_set_wins", b_rdata, 32'h3);
    btn_confirm = 0;
    a_req = 1; a_addr = 32'h10;
    b_req = 1; b_we = 0; b_addr = 32'hFFFF_0108;
    step();
    reset = 1'b0;
    #1;
    chk("arst_a_rvalid", a_rvalid, 0);
    chk("arst_b_rvalid", b_rvalid, 0);
    chk("arst_b_err", b_err, 0);
    chk("arst_a_rdata", a_rdata, 0);
    chk("arst_b_rdata", b_rdata, 0);
    chk("arst_out_regs", out_regs, 0);
    a_req = 0; b_req = 0;
    repeat (2) step();
    reset = 1'b1;
    ar(32'h10);
    chk("ram_survives_a", a_rdata, 32'hDEAD55EF);
    bop(0, 4'h0, 32'h20, 0);
    chk("ram_survives_b", b_rdata, 32'h0202_0202);
    bop(0, 4'h0, 32'hFFFF_0108, 0);
    chk("out_reg_cleared", b_rdata, 32'h0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
